// File: rtl/dac_spi_tx.sv
// SPI frame driver for a DAC7311-class converter: PD1 PD0 D11..D0 X X, MSB first.
// Define DAC_SIGNED_IN_EN to treat din as two's complement (converted to offset binary).
module dac_spi_tx #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pls,
    input  logic [11:0] din,
    output logic        sclk,
    output logic        sync_n,
    output logic        sdo,
    output logic        busy,
    output logic        done,
    output logic        ovr
);

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        SHIFT_LO,
        SHIFT_HI,
        TRAIL
    } state_t;

    localparam logic [7:0] HMAX = 8'(CLK_DIV - 1);

    state_t      state_q, state_d;
    logic [7:0]  hcnt_q, hcnt_d;
    logic [3:0]  bcnt_q, bcnt_d;
    logic [15:0] sr_q, sr_d;
    logic        sclk_q, sclk_d;
    logic        sync_n_q, sync_n_d;
    logic        sdo_q, sdo_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        ovr_q, ovr_d;

    logic        tick;
    logic [11:0] din_m;
    logic [15:0] frame;

    assign tick = (hcnt_q == HMAX);

`ifdef DAC_SIGNED_IN_EN
    assign din_m = {~din[11], din[10:0]};
`else
    assign din_m = din;
`endif

    assign frame = {2'b00, din_m, 2'b00};

    always_comb begin
        state_d  = state_q;
        bcnt_d   = bcnt_q;
        sr_d     = sr_q;
        sclk_d   = sclk_q;
        sync_n_d = sync_n_q;
        sdo_d    = sdo_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        ovr_d    = ovr_q | (pls && (state_q != IDLE));
        // Every non-idle tick is also a state change, so hcnt restarts there.
        hcnt_d   = (state_q == IDLE || tick) ? 8'd0 : hcnt_q + 8'd1;

        case (state_q)
            IDLE: begin
                sclk_d   = 1'b1;
                sync_n_d = 1'b1;
                sdo_d    = 1'b0;
                busy_d   = 1'b0;
                if (pls) begin
                    sr_d     = frame;
                    sdo_d    = frame[15];
                    sync_n_d = 1'b0;
                    busy_d   = 1'b1;
                    bcnt_d   = 4'd0;
                    state_d  = LEAD;
                end
            end
            LEAD: begin
                if (tick) begin
                    sclk_d  = 1'b0;
                    state_d = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                if (tick) begin
                    sclk_d = 1'b1;
                    if (bcnt_q != 4'd15) begin
                        sr_d    = {sr_q[14:0], 1'b0};
                        sdo_d   = sr_q[14];
                        bcnt_d  = bcnt_q + 4'd1;
                        state_d = SHIFT_HI;
                    end else begin
                        sync_n_d = 1'b1;
                        sdo_d    = 1'b0;
                        state_d  = TRAIL;
                    end
                end
            end
            SHIFT_HI: begin
                if (tick) begin
                    sclk_d  = 1'b0;
                    state_d = SHIFT_LO;
                end
            end
            TRAIL: begin
                if (tick) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            hcnt_q   <= 8'd0;
            bcnt_q   <= 4'd0;
            sr_q     <= 16'd0;
            sclk_q   <= 1'b1;
            sync_n_q <= 1'b1;
            sdo_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            hcnt_q   <= hcnt_d;
            bcnt_q   <= bcnt_d;
            sr_q     <= sr_d;
            sclk_q   <= sclk_d;
            sync_n_q <= sync_n_d;
            sdo_q    <= sdo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ovr_q    <= ovr_d;
        end
    end

    assign sclk   = sclk_q;
    assign sync_n = sync_n_q;
    assign sdo    = sdo_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign ovr    = ovr_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Directed bench for dac_spi_tx: CLK_DIV=2 and CLK_DIV=1 instances, frames captured
// on SCLK falling edges. Expected words follow DAC_SIGNED_IN_EN when defined.
module tb_dac_spi_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pls = 1'b0;
    logic [11:0] din = 12'h000;
    bit          sel = 1'b0;

    logic pls2, sclk2, sync2, sdo2, busy2, done2, ovr2;
    logic pls1, sclk1, sync1, sdo1, busy1, done1, ovr1;
    logic m_sclk, m_sync_n, m_sdo, m_busy, m_done, m_ovr;

    int n_chk = 0;
    int n_fail = 0;

    assign pls2 = pls & ~sel;
    assign pls1 = pls & sel;

    assign m_sclk   = sel ? sclk1 : sclk2;
    assign m_sync_n = sel ? sync1 : sync2;
    assign m_sdo    = sel ? sdo1  : sdo2;
    assign m_busy   = sel ? busy1 : busy2;
    assign m_done   = sel ? done1 : done2;
    assign m_ovr    = sel ? ovr1  : ovr2;

    dac_spi_tx #(.CLK_DIV(2)) u2 (
        .clk(clk), .rst(rst), .pls(pls2), .din(din),
        .sclk(sclk2), .sync_n(sync2), .sdo(sdo2),
        .busy(busy2), .done(done2), .ovr(ovr2)
    );

    dac_spi_tx #(.CLK_DIV(1)) u1 (
        .clk(clk), .rst(rst), .pls(pls1), .din(din),
        .sclk(sclk1), .sync_n(sync1), .sdo(sdo1),
        .busy(busy1), .done(done1), .ovr(ovr1)
    );

    always #10 clk = ~clk;

`ifdef DAC_SIGNED_IN_EN
    localparam logic [15:0] W_ABC = 16'h0AF0;
    localparam logic [15:0] W_001 = 16'h2004;
    localparam logic [15:0] W_TAB [4] = '{16'h2000, 16'h1FFC, 16'h3694, 16'h3FFC};
`else
    localparam logic [15:0] W_ABC = 16'h2AF0;
    localparam logic [15:0] W_001 = 16'h0004;
    localparam logic [15:0] W_TAB [4] = '{16'h0000, 16'h3FFC, 16'h1694, 16'h1FFC};
`endif
    localparam logic [11:0] D_TAB [4] = '{12'h000, 12'hFFF, 12'h5A5, 12'h7FF};

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // c=0 is the cycle right after the accepting edge; stops at done.
    task automatic measure(input logic [11:0] d, input bit pre,
                           input int extra_at, input logic [11:0] nd,
                           output logic [15:0] word, output int falls,
                           output int slow, output int bhi, output int dat);
        logic prev;
        if (!pre) begin
            @(posedge clk); #1;
            din = d;
            pls = 1'b1;
        end
        @(posedge clk); #1;
        pls = 1'b0;
        din = 12'h555;
        word = 16'h0; falls = 0; slow = 0; bhi = 0; dat = -1;
        prev = 1'b1;
        for (int c = 0; c < 300; c++) begin
            if (prev && !m_sclk) begin
                word = {word[14:0], m_sdo};
                falls++;
            end
            prev = m_sclk;
            if (!m_sync_n) slow++;
            if (m_busy) bhi++;
            if (c == extra_at) begin
                pls = 1'b1;
                din = nd;
            end
            if (m_done) begin
                dat = c;
                break;
            end
            @(posedge clk); #1;
            pls = 1'b0;
        end
    endtask

    logic [15:0] w;
    int f, sl, bh, dt;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_u2", {sclk2, sync2, sdo2, busy2, done2, ovr2}, 6'b110000);
        chk("reset_u1", {sclk1, sync1, sdo1, busy1, done1, ovr1}, 6'b110000);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        measure(12'hABC, 1'b0, -1, 12'h0, w, f, sl, bh, dt);
        chk("single_word", w, W_ABC);
        chk("single_falls", f, 16);
        chk("single_synclow", sl, 64);
        chk("single_busy", bh, 66);
        chk("single_done_at", dt, 66);
        chk("single_done_busy", m_busy, 1'b0);
        @(posedge clk); #1;
        chk("done_width", m_done, 1'b0);

        measure(12'hABC, 1'b0, 66, 12'h001, w, f, sl, bh, dt);
        chk("b2b_first_word", w, W_ABC);
        chk("b2b_first_done", dt, 66);
        measure(12'h001, 1'b1, -1, 12'h0, w, f, sl, bh, dt);
        chk("b2b_second_word", w, W_001);
        chk("b2b_second_done", dt, 66);
        chk("b2b_ovr", m_ovr, 1'b0);

        measure(12'hABC, 1'b0, 10, 12'h000, w, f, sl, bh, dt);
        chk("ovr_word", w, W_ABC);
        chk("ovr_done_at", dt, 66);
        chk("ovr_flag", m_ovr, 1'b1);
        bh = 0;
        repeat (80) begin
            @(posedge clk); #1;
            if (m_busy) bh++;
        end
        chk("ovr_no_second_frame", bh, 0);
        chk("ovr_sticky", m_ovr, 1'b1);

        @(posedge clk); #1;
        din = 12'hABC;
        pls = 1'b1;
        @(posedge clk); #1;
        pls = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("mid_busy_before", {m_sclk, m_sync_n, m_busy}, 3'b001);
        rst = 1'b1;
        #2;
        chk("mid_reset", {sclk2, sync2, sdo2, busy2, done2, ovr2}, 6'b110000);
        @(posedge clk); #1;
        rst = 1'b0;
        measure(12'h001, 1'b0, -1, 12'h0, w, f, sl, bh, dt);
        chk("after_rst_word", w, W_001);
        chk("after_rst_done", dt, 66);
        chk("after_rst_ovr", m_ovr, 1'b0);

        sel = 1'b1;
        for (int i = 0; i < 4; i++) begin
            measure(D_TAB[i], 1'b0, -1, 12'h0, w, f, sl, bh, dt);
            chk($sformatf("div1_word%0d", i), w, W_TAB[i]);
            chk($sformatf("div1_synclow%0d", i), sl, 32);
            chk($sformatf("div1_done%0d", i), dt, 33);
            repeat (100 - 35) @(posedge clk);
        end
        #1;
        chk("div1_ovr", m_ovr, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dac_spi_tx.md
# dac_spi_tx

Serial DAC driver that sits directly downstream of the sine generator. It samples the 12-bit sine word on each 500 kHz `pls` strobe and shifts it out as a 16-bit SPI frame to a DAC7311-class converter. Frame format is PD1 PD0 D11..D0 X X, MSB first. Output pins are registered and glitch-free.

## Interface
- `CLK_DIV`, default 2: SCLK half-period in `clk` cycles; legal range 1..255.
- `clk`  in  1: system clock.
- `rst`  in  1: asynchronous, active-high reset.
- `pls`  in  1: sample strobe, one `clk` wide, 500 kHz.
- `din`  in  12: sample word (`sind` from sine generator).
- `sclk`  out  1: SPI clock, idles high.
- `sync_n`  out  1: DAC frame sync, active low.
- `sdo`  out  1: serial data; changes on SCLK rising, DAC samples on falling.
- `busy`  out  1: frame in progress.
- `done`  out  1: one-cycle pulse at frame end.
- `ovr`  out  1: sticky overrun flag, set by `pls` while busy.

## Operation
- Frame word (16 b) = {2'b00, din_latched, 2'b00}; PD bits fixed 00 (normal mode). Sent MSB first.
- Half-period counter `hcnt` runs 0..CLK_DIV-1; `tick` = (hcnt == CLK_DIV-1). `hcnt` is cleared on every state entry.
- Bit counter 0..15 tracks completed SCLK falling edges.
- FSM states:
  - IDLE: sync_n=1, sclk=1, sdo=0, busy=0. On `pls`: latch din into the shift register, drive sync_n=0, sdo=frame[15], busy=1, go to LEAD.
  - LEAD: sclk=1. On tick: sclk=0, go to SHIFT_LO.
  - SHIFT_LO: sclk=0. On tick:
    - If bit count < 15: sclk=1, shift sdo to the next bit, increment count, go to SHIFT_HI.
    - If bit count = 15: sclk=1, sync_n=1, sdo=0, go to TRAIL.
  - SHIFT_HI: sclk=1. On tick: sclk=0, go to SHIFT_LO.
  - TRAIL: sync_n=1, sclk=1. On tick: busy=0, done=1, go to IDLE.
- `pls` seen in any state other than IDLE is ignored and sets `ovr`. `ovr` is cleared only by `rst`.
- `pls` in the same cycle as `done` is accepted, because the FSM is already in IDLE.
- `din` is read only on the accepting `pls` edge. Changes during a frame have no effect.

## Timing
- Reset values, applied asynchronously and immediately, including mid-frame: sclk=1, sync_n=1, sdo=0, busy=0, done=0, ovr=0, FSM=IDLE.
- Latency: `pls` high at edge k gives sync_n=0, busy=1 and sdo=bit15 visible after edge k.
- sync_n stays low for exactly 32·CLK_DIV cycles. busy stays high for exactly 33·CLK_DIV cycles.
- `done` is high in the first cycle with busy=0.
- Exactly 16 SCLK falling edges per frame, all while sync_n=0. sdo is stable for ≥CLK_DIV cycles around each falling edge.
- sync_n rises together with the 16th-bit SCLK rising edge.
- Minimum strobe spacing with no overrun: 33·CLK_DIV+1 cycles. At 50 MHz with CLK_DIV=2 that is 67 cycles, against a 100-cycle pls period.

## Configuration
- `DAC_SIGNED_IN_EN` defined: `din` is treated as two's complement. din[11] is inverted at latch time, converting it to offset binary before framing.
- Macro undefined: `din` is framed unmodified as unsigned straight binary.
- Timing is identical in both builds.

## Test plan
- Reset: assert rst mid-frame at bit 7 → all outputs return to reset values in the same cycle; the next `pls` starts a clean frame.
- Single frame, CLK_DIV=2, din=12'hABC, macro off → 16 bits captured on SCLK falling edges = 16'h2AF0; sync_n low 64 cycles; done pulses 66 cycles after `pls`.
- Same stimulus with `DAC_SIGNED_IN_EN` → captured word 16'h0AF0; timing unchanged.
- Overrun: second `pls` 10 cycles after the first → frame 1 completes intact, no second frame starts, ovr=1 and stays 1 until rst.
- Back-to-back: `pls` exactly in the `done` cycle with din=12'h001 → new frame starts next cycle, captured 16'h0004, ovr stays 0.
- CLK_DIV=1, continuous 500 kHz `pls` at 50 MHz with ROM-driven din → every captured frame equals the latched din, zero overruns, sync_n low exactly 32 cycles per frame.
